present_key_scheduler: RTL and testbench
========================================

// Module: present_key_scheduler
// PURPOSE
//  Sequential PRESENT round-key generator, successor to the combinational key-schedule step.
//  - Loads an 80- or 128-bit cipher key on start.
//  - Streams round keys K1..K(NUM_ROUNDS+1) over a valid/ready handshake.
//  - Sits between key input and the round datapath; no cipher-state logic inside.
// PARAMETERS
//  KEY_SIZE    80  cipher key width; legal values 80 or 128 only (elaboration error otherwise)
//  NUM_ROUNDS  31  rounds; NUM_ROUNDS+1 round keys emitted; legal 1..31
//  RK_W        64  round-key width = key_reg[KEY_SIZE-1 -: RK_W]; fixed 64 for PRESENT
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         reset, asynchronous, active-high
//  start     in   1         load key_in and begin schedule; honoured only in IDLE
//  key_in    in   KEY_SIZE  cipher key, sampled on the cycle start is accepted
//  busy      out  1         high in GEN and DONE states
//  rk_valid  out  1         rk_data/rk_index valid
//  rk_ready  in   1         consumer accepts current round key
//  rk_data   out  RK_W      current round key
//  rk_index  out  6         round-key number, 1..NUM_ROUNDS+1
//  done      out  1         one-cycle pulse after final key accepted
//  rd_idx    in   6         random-access index (KEY_STORE_EN only)
//  rd_key    out  RK_W      stored round key rd_idx (KEY_STORE_EN only)
// BEHAVIOUR
//  Reset values: key_reg=0, ctr=0, state=IDLE, busy=0, rk_valid=0, rk_data=0, rk_index=0, done=0.
//  FSM:
//   - IDLE -> GEN on start: key_reg<=key_in, ctr<=1.
//   - GEN -> DONE on handshake when ctr==NUM_ROUNDS+1.
//   - DONE -> IDLE after 1 cycle; done=1 for that cycle only.
//  Latency: start at cycle t -> rk_valid=1, rk_index=1, rk_data=key_in[top 64] at t+1.
//  Handshake: key advances only on rk_valid&&rk_ready. Throughput is 1 key/cycle.
//   - rk_valid stays high between keys in GEN.
//   - rk_data/rk_index hold stable while rk_ready=0.
//  Update on handshake with ctr<NUM_ROUNDS+1 (ctr is 5-bit XOR salt, value = current index):
//   - 80-bit: k=rotl(key_reg,61); k[79:76]=S(k[79:76]); k[19:15]^=ctr.
//   - 128-bit: k=rotl(key_reg,61); k[127:124]=S(k[127:124]); k[123:120]=S(k[123:120]); k[66:62]^=ctr.
//   - Then key_reg<=k, ctr<=ctr+1.
//   - S = PRESENT S-box C56B90AD3EF84712.
//  Boundary conditions:
//   - start while busy: ignored, no reload.
//   - start in DONE cycle: ignored.
//   - start in IDLE in the same cycle done deasserts: accepted.
//   - Final handshake (index NUM_ROUNDS+1): no key update; rk_valid drops next cycle.
//   - rst mid-schedule: all state returns to reset values immediately; partial schedule discarded.
//   - rk_ready high outside GEN: no effect.
// CONFIGURATION
//  KEY_STORE_EN defined:
//   - Each accepted key is written to an internal RK_W x (NUM_ROUNDS+1) array at rk_index-1.
//   - rd_key = array[rd_idx-1], combinational; reverse-order decryption reads after done.
//   - rd_idx=0 or >NUM_ROUNDS+1 returns 0.
//   - Array resets to 0; start does not clear it, entries are overwritten by the new schedule.
//  KEY_STORE_EN undefined: no array; rd_key tied to 0; rd_idx unused.
// TESTING
//  1. KEY_SIZE=80, key_in=0, rk_ready=1: K1=0000000000000000, K2=C000000000000000, K3=5000180000000001;
//     done pulses 32 cycles after first rk_valid.
//  2. Backpressure: rk_ready toggled 1,0,0,1 -> rk_data/rk_index held during 0 cycles; no key skipped or duplicated.
//  3. start asserted at rk_index=10 -> ignored; remaining sequence identical to the uninterrupted run.
//  4. rst pulse at rk_index=17 -> all outputs 0 the same cycle;
//     restart with the same key reproduces K1..K32 exactly.
//  5. KEY_SIZE=128, key_in=0: K2=CC00000000000000;
//     32 keys emitted; reference model comparison for all keys.
//  6. KEY_STORE_EN, 80-bit, key FFFFFFFFFFFFFFFFFFFF: after done, sweep rd_idx 32..1
//     -> matches streamed keys; rd_idx=0 and rd_idx=33 -> 0.

Source files
------------

// File: rtl/present_key_scheduler.sv
// present_key_scheduler: sequential PRESENT round-key generator for 80/128-bit keys,
// streaming K1..K(NUM_ROUNDS+1) over valid/ready. Define KEY_STORE_EN to keep a readable round-key store.
module present_key_scheduler #(
    parameter int KEY_SIZE   = 80,
    parameter int NUM_ROUNDS = 31,
    parameter int RK_W       = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [RK_W-1:0]     rk_data,
    output logic [5:0]          rk_index,
    output logic                done,
    input  logic [5:0]          rd_idx,
    output logic [RK_W-1:0]     rd_key
);

    localparam int         NUM_KEYS = NUM_ROUNDS + 1;
    localparam logic [5:0] LAST_IDX = 6'(NUM_KEYS);

    generate
        if ((KEY_SIZE != 80) && (KEY_SIZE != 128)) begin : g_bad_key_size
            $error("present_key_scheduler: KEY_SIZE must be 80 or 128");
        end
        if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 31)) begin : g_bad_rounds
            $error("present_key_scheduler: NUM_ROUNDS must be 1..31");
        end
        if (RK_W != 64) begin : g_bad_rk_w
            $error("present_key_scheduler: RK_W must be 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    state_t              state_r, state_s;
    logic [KEY_SIZE-1:0] key_r, key_s;
    logic [5:0]          ctr_r, ctr_s;
    logic                busy_r, valid_r, done_r;
    logic [KEY_SIZE-1:0] rot_s, upd_s;

    assign rot_s = {key_r[KEY_SIZE-62:0], key_r[KEY_SIZE-1:KEY_SIZE-61]};

    // The low five bits of the index act as the round-counter salt.
    generate
        if (KEY_SIZE == 128) begin : g_upd128
            // 128-bit schedule step: two S-boxes on the top byte, salt at bits 66:62.
            always_comb begin
                upd_s          = rot_s;
                upd_s[127:124] = sbox(rot_s[127:124]);
                upd_s[123:120] = sbox(rot_s[123:120]);
                upd_s[66:62]   = rot_s[66:62] ^ ctr_r[4:0];
            end
        end else begin : g_upd80
            // 80-bit schedule step: one S-box on the top nibble, salt at bits 19:15.
            always_comb begin
                upd_s                  = rot_s;
                upd_s[KEY_SIZE-1 -: 4] = sbox(rot_s[KEY_SIZE-1 -: 4]);
                upd_s[19:15]           = rot_s[19:15] ^ ctr_r[4:0];
            end
        end
    endgenerate

    // Next-state, key and index logic; the key only moves on an accepted handshake.
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        ctr_s   = ctr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_GEN;
                    key_s   = key_in;
                    ctr_s   = 6'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (rk_ready) begin
                    if (ctr_r == LAST_IDX) begin
                        state_s = ST_DONE;
                    end else begin
                        key_s = upd_s;
                        ctr_s = ctr_r + 6'd1;
                    end
                end else begin
                    state_s = ST_GEN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, key and status flags registered together so outputs track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            key_r   <= {KEY_SIZE{1'b0}};
            ctr_r   <= 6'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            key_r   <= key_s;
            ctr_r   <= ctr_s;
            busy_r  <= (state_s != ST_IDLE);
            valid_r <= (state_s == ST_GEN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign busy     = busy_r;
    assign rk_valid = valid_r;
    assign done     = done_r;
    assign rk_data  = key_r[KEY_SIZE-1 -: RK_W];
    assign rk_index = ctr_r;

`ifdef KEY_STORE_EN
    logic            hs_s;
    logic [RK_W-1:0] store_r [NUM_KEYS];

    assign hs_s = valid_r & rk_ready;

    // Each accepted key lands in slot index-1; a new schedule overwrites in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                store_r[i] <= {RK_W{1'b0}};
            end
        end else if (hs_s) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (ctr_r == 6'(i + 1)) begin
                    store_r[i] <= rk_data;
                end
            end
        end
    end

    // Random-access read; out-of-range indices match no slot and return zero.
    always_comb begin
        rd_key = {RK_W{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            rd_key = rd_key | ({RK_W{rd_idx == 6'(i + 1)}} & store_r[i]);
        end
    end
`else
    logic unused_rd_idx;

    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = {RK_W{1'b0}};
`endif

endmodule

// File: tb/tb_present_key_scheduler.sv
// Directed testbench for present_key_scheduler: 80-bit and 128-bit instances checked against
// hand-computed keys and a small schedule model.
module tb_present_key_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, rk_ready_a, busy_a, rk_valid_a, done_a;
    logic [79:0] key_a;
    logic [63:0] rk_data_a, rd_key_a;
    logic [5:0]  rk_index_a, rd_idx_a;
    logic        start_b, rk_ready_b, busy_b, rk_valid_b, done_b;
    logic [127:0] key_b;
    logic [63:0] rk_data_b, rd_key_b;
    logic [5:0]  rk_index_b, rd_idx_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_a [1:32];
    logic [63:0] exp_b [1:32];
    logic [63:0] hand_a [1:3];

    present_key_scheduler #(.KEY_SIZE(80), .NUM_ROUNDS(31), .RK_W(64)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_a), .busy(busy_a),
        .rk_valid(rk_valid_a), .rk_ready(rk_ready_a), .rk_data(rk_data_a),
        .rk_index(rk_index_a), .done(done_a), .rd_idx(rd_idx_a), .rd_key(rd_key_a)
    );

    present_key_scheduler #(.KEY_SIZE(128), .NUM_ROUNDS(31), .RK_W(64)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_b), .busy(busy_b),
        .rk_valid(rk_valid_b), .rk_ready(rk_ready_b), .rk_data(rk_data_b),
        .rk_index(rk_index_b), .done(done_b), .rd_idx(rd_idx_b), .rd_key(rd_key_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[63 - 4 * int'(x) -: 4];
    endfunction

    function automatic logic [79:0] step80(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r = (k << 61) | (k >> 19);
        r[79:76] = sb(r[79:76]);
        r[19:15] = r[19:15] ^ c;
        return r;
    endfunction

    function automatic logic [127:0] step128(input logic [127:0] k, input logic [4:0] c);
        logic [127:0] r;
        r = (k << 61) | (k >> 67);
        r[127:124] = sb(r[127:124]);
        r[123:120] = sb(r[123:120]);
        r[66:62] = r[66:62] ^ c;
        return r;
    endfunction

    task automatic build_a(input logic [79:0] key);
        logic [79:0] k;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            exp_a[i] = k[79:16];
            k = step80(k, 5'(i));
        end
    endtask

    task automatic build_b(input logic [127:0] key);
        logic [127:0] k;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            exp_b[i] = k[127:64];
            k = step128(k, 5'(i));
        end
    endtask

    task automatic start_key_a(input logic [79:0] k);
        key_a   = k;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Streams one 80-bit schedule; optional backpressure, stray start, reset abort, start-in-DONE.
    task automatic stream_a(input bit bp, input int inject_at, input int rst_at,
                            input bit start_in_done, input bit hand);
        int nxt;
        bit fin;
        nxt = 1;
        fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (rst_at != 0 && rk_index_a == 6'(rst_at)) begin
                rst = 1'b1;
                #1;
                chk("rst_busy",  128'(busy_a),     128'(1'b0));
                chk("rst_valid", 128'(rk_valid_a), 128'(1'b0));
                chk("rst_data",  128'(rk_data_a),  128'(64'h0));
                chk("rst_index", 128'(rk_index_a), 128'(6'd0));
                chk("rst_done",  128'(done_a),     128'(1'b0));
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (nxt <= 32) begin
                chk("valid", 128'(rk_valid_a), 128'(1'b1));
                chk("index", 128'(rk_index_a), 128'(nxt));
                chk("data",  128'(rk_data_a),  128'(exp_a[nxt]));
                if (hand && nxt <= 3) chk("hand_key", 128'(rk_data_a), 128'(hand_a[nxt]));
                rk_ready_a = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
                start_a    = (inject_at != 0) && (nxt == inject_at);
                if (start_a) key_a = 80'hA5A5_5A5A_F0F0_0F0F_1234;
                if (rk_ready_a) nxt++;
            end else begin
                chk("done",       128'(done_a),     128'(1'b1));
                chk("done_valid", 128'(rk_valid_a), 128'(1'b0));
                chk("done_busy",  128'(busy_a),     128'(1'b1));
                if (!bp) chk("done_cycle", 128'(cyc), 128'(32));
                start_a = start_in_done;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        chk("finished", 128'(fin), 128'(1'b1));
        if (fin) begin
            chk("idle_done",  128'(done_a),     128'(1'b0));
            chk("idle_busy",  128'(busy_a),     128'(1'b0));
            chk("idle_valid", 128'(rk_valid_a), 128'(1'b0));
        end
    endtask

    initial begin
        int  nxt;
        bit  fin;
        rst = 1'b1;
        start_a = 1'b0; key_a = 80'h0; rk_ready_a = 1'b1; rd_idx_a = 6'd0;
        start_b = 1'b0; key_b = 128'h0; rk_ready_b = 1'b1; rd_idx_b = 6'd0;
        hand_a[1] = 64'h0000000000000000;
        hand_a[2] = 64'hC000000000000000;
        hand_a[3] = 64'h5000180000000001;
        #12;
        chk("reset_busy",  128'(busy_a),     128'(1'b0));
        chk("reset_valid", 128'(rk_valid_a), 128'(1'b0));
        chk("reset_data",  128'(rk_data_a),  128'(64'h0));
        chk("reset_index", 128'(rk_index_a), 128'(6'd0));
        chk("reset_done",  128'(done_a),     128'(1'b0));
        chk("reset_b_valid", 128'(rk_valid_b), 128'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_idle_valid", 128'(rk_valid_a), 128'(1'b0));
        chk("ready_idle_index", 128'(rk_index_a), 128'(6'd0));

        // Zero key with hand-computed K1..K3 and done timing.
        build_a(80'h0);
        start_key_a(80'h0);
        stream_a(1'b0, 0, 0, 1'b0, 1'b1);

        // Backpressure with ready pattern 1,0,0,1.
        build_a(80'h0123_4567_89AB_CDEF_0123);
        start_key_a(80'h0123_4567_89AB_CDEF_0123);
        stream_a(1'b1, 0, 0, 1'b0, 1'b0);

        // Stray start at index 10 and in the DONE cycle, then restart as done drops.
        build_a(80'h1357_9BDF_0246_8ACE_1122);
        start_key_a(80'h1357_9BDF_0246_8ACE_1122);
        stream_a(1'b0, 10, 0, 1'b1, 1'b0);
        start_key_a(80'h1357_9BDF_0246_8ACE_1122);
        stream_a(1'b0, 0, 0, 1'b0, 1'b0);

        // Reset at index 17, then the same key reproduces the full schedule.
        build_a(80'hFEDC_BA98_7654_3210_CAFE);
        start_key_a(80'hFEDC_BA98_7654_3210_CAFE);
        stream_a(1'b0, 0, 17, 1'b0, 1'b0);
        start_key_a(80'hFEDC_BA98_7654_3210_CAFE);
        stream_a(1'b0, 0, 0, 1'b0, 1'b0);

        // 128-bit zero key against the model and the hand value of K2.
        build_b(128'h0);
        key_b   = 128'h0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        nxt = 1;
        fin = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (nxt <= 32) begin
                chk("b_valid", 128'(rk_valid_b), 128'(1'b1));
                chk("b_index", 128'(rk_index_b), 128'(nxt));
                chk("b_data",  128'(rk_data_b),  128'(exp_b[nxt]));
                if (nxt == 2) chk("b_hand_k2", 128'(rk_data_b), 128'(64'hCC00000000000000));
                nxt++;
            end else begin
                chk("b_done", 128'(done_b), 128'(1'b1));
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("b_finished", 128'(fin), 128'(1'b1));
        chk("b_rd_idx0", 128'(rd_key_b), 128'(64'h0));

`ifdef KEY_STORE_EN
        build_a(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        start_key_a(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        stream_a(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 32; i >= 1; i--) begin
            rd_idx_a = 6'(i);
            #1;
            chk("store_rd", 128'(rd_key_a), 128'(exp_a[i]));
        end
        rd_idx_a = 6'd0;
        #1;
        chk("store_rd0", 128'(rd_key_a), 128'(64'h0));
        rd_idx_a = 6'd33;
        #1;
        chk("store_rd33", 128'(rd_key_a), 128'(64'h0));
`else
        rd_idx_a = 6'd1;
        #1;
        chk("nostore_rd1", 128'(rd_key_a), 128'(64'h0));
        rd_idx_a = 6'd5;
        #1;
        chk("nostore_rd5", 128'(rd_key_a), 128'(64'h0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
